// File: rtl/load_store_unit.sv
// Load/store unit between the datapath and a word-organised data memory.
// Handles byte/half/word access, read-modify-write for sub-word stores and access checks.
module load_store_unit #(
    parameter int DEPTH_WORDS = 512
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [1:0]  req_size,
    input  logic        req_unsigned,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic [1:0]  resp_error,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic        mem_read,
    output logic        mem_write,
    input  logic [31:0] mem_rdata
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RD   = 2'd1;
    localparam logic [1:0] ST_WR   = 2'd2;
    localparam logic [1:0] ST_RESP = 2'd3;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;
    localparam logic [1:0] SZ_ILL  = 2'b11;

    localparam logic [1:0] ERR_OK    = 2'b00;
    localparam logic [1:0] ERR_ALIGN = 2'b01;
    localparam logic [1:0] ERR_RANGE = 2'b10;
    localparam logic [1:0] ERR_SIZE  = 2'b11;

    localparam logic [29:0] DEPTH_IDX = 30'(DEPTH_WORDS);

    logic [1:0]  state_q, state_d;
    logic [31:0] addr_q, addr_d;
    logic [1:0]  size_q, size_d;
    logic        unsigned_q, unsigned_d;
    logic        write_q, write_d;
    logic [31:0] wdata_q, wdata_d;
    logic [1:0]  err_q, err_d;
    logic [31:0] hold_q, hold_d;

    logic        accept;
    logic [1:0]  acc_err;

    // Merge right-aligned store data into the held word at the addressed lane.
    function automatic logic [31:0] merge_store(input logic [31:0] held,
                                                input logic [31:0] wdata,
                                                input logic [1:0]  size,
                                                input logic [1:0]  off);
        logic [31:0] r;
        r = held;
        case (size)
            SZ_BYTE: r[{off, 3'b000} +: 8]     = wdata[7:0];
            SZ_HALF: r[{off[1], 4'b0000} +: 16] = wdata[15:0];
            default: r = wdata;
        endcase
        return r;
    endfunction

    function automatic logic [31:0] extract_load(input logic [31:0] held,
                                                 input logic [1:0]  size,
                                                 input logic [1:0]  off,
                                                 input logic        uns);
        logic [7:0]  b;
        logic [15:0] h;
        logic [31:0] r;
        b = held[{off, 3'b000} +: 8];
        h = held[{off[1], 4'b0000} +: 16];
        case (size)
            SZ_BYTE: r = uns ? {24'b0, b} : {{24{b[7]}}, b};
            SZ_HALF: r = uns ? {16'b0, h} : {{16{h[15]}}, h};
            default: r = held;
        endcase
        return r;
    endfunction

    assign req_ready = (state_q == ST_IDLE) && reset;
    assign accept    = req_valid && req_ready;

    // Checks are prioritised: size first, then alignment, then range.
    always_comb begin
        acc_err = ERR_OK;
        if (req_size == SZ_ILL) begin
            acc_err = ERR_SIZE;
        end else if ((req_size == SZ_HALF && req_addr[0]) ||
                     (req_size == SZ_WORD && req_addr[1:0] != 2'b00)) begin
            acc_err = ERR_ALIGN;
        end else if (req_addr[31:2] >= DEPTH_IDX) begin
            acc_err = ERR_RANGE;
        end
    end

    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        size_d     = size_q;
        unsigned_d = unsigned_q;
        write_d    = write_q;
        wdata_d    = wdata_q;
        err_d      = err_q;
        hold_d     = hold_q;
        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    addr_d     = req_addr;
                    size_d     = req_size;
                    unsigned_d = req_unsigned;
                    write_d    = req_write;
                    wdata_d    = req_wdata;
                    err_d      = acc_err;
                    if (acc_err != ERR_OK) begin
                        state_d = ST_RESP;
                    end else if (req_write && req_size == SZ_WORD) begin
                        state_d = ST_WR;
                    end else begin
                        state_d = ST_RD;
                    end
                end
            end
            ST_RD: begin
                hold_d  = mem_rdata;
                state_d = write_q ? ST_WR : ST_RESP;
            end
            ST_WR:   state_d = ST_RESP;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q    <= ST_IDLE;
            addr_q     <= '0;
            size_q     <= '0;
            unsigned_q <= 1'b0;
            write_q    <= 1'b0;
            wdata_q    <= '0;
            err_q      <= ERR_OK;
            hold_q     <= '0;
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            size_q     <= size_d;
            unsigned_q <= unsigned_d;
            write_q    <= write_d;
            wdata_q    <= wdata_d;
            err_q      <= err_d;
            hold_q     <= hold_d;
        end
    end

    // Memory strobes decode straight from state so reset drops them asynchronously.
    always_comb begin
        mem_read  = (state_q == ST_RD);
        mem_write = (state_q == ST_WR);
        mem_addr  = '0;
        mem_wdata = '0;
        if (state_q == ST_RD || state_q == ST_WR) begin
            mem_addr = {2'b00, addr_q[31:2]};
        end
        if (state_q == ST_WR) begin
            mem_wdata = merge_store(hold_q, wdata_q, size_q, addr_q[1:0]);
        end
    end

    always_comb begin
        resp_valid = (state_q == ST_RESP);
        resp_error = ERR_OK;
        resp_rdata = '0;
        if (state_q == ST_RESP) begin
            resp_error = err_q;
            if (!write_q && err_q == ERR_OK) begin
                resp_rdata = extract_load(hold_q, size_q, addr_q[1:0], unsigned_q);
            end
        end
    end

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit with a negedge-commit data memory model.
module tb_load_store_unit;

    logic        clock = 1'b0;
    logic        reset;
    logic        req_valid;
    logic        req_ready;
    logic        req_write;
    logic [1:0]  req_size;
    logic        req_unsigned;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic [1:0]  resp_error;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_read;
    logic        mem_write;
    logic [31:0] mem_rdata;

    logic [31:0] mem [0:511];
    logic        pl_en = 1'b0;
    logic [8:0]  pl_idx = '0;
    logic [31:0] pl_data = '0;

    int checks = 0;
    int errors = 0;

    logic [31:0] r, wa, wdd;
    logic [1:0]  e;
    int          lat, nrd, nwr;

    load_store_unit #(.DEPTH_WORDS(512)) dut (
        .clock(clock), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
        .req_size(req_size), .req_unsigned(req_unsigned), .req_addr(req_addr),
        .req_wdata(req_wdata), .resp_valid(resp_valid), .resp_rdata(resp_rdata),
        .resp_error(resp_error), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_read(mem_read), .mem_write(mem_write), .mem_rdata(mem_rdata)
    );

    always #5 clock = ~clock;

    assign mem_rdata = mem[mem_addr[8:0]];

    always @(negedge clock) begin
        if (pl_en) mem[pl_idx] <= pl_data;
        else if (mem_write) mem[mem_addr[8:0]] <= mem_wdata;
    end

    task automatic preload(input logic [8:0] idx, input logic [31:0] data);
        @(posedge clock);
        pl_idx = idx; pl_data = data; pl_en = 1'b1;
        @(negedge clock);
        #1 pl_en = 1'b0;
    endtask

    // Issue one request from IDLE and observe the transaction until its response.
    task automatic do_req(input logic wr, input logic [1:0] sz, input logic uns,
                          input logic [31:0] addr, input logic [31:0] wd,
                          output logic [31:0] rd, output logic [1:0] er,
                          output int l, output int nr, output int nw,
                          output logic [31:0] waddr, output logic [31:0] wdat);
        bit done;
        @(negedge clock);
        req_valid = 1'b1; req_write = wr; req_size = sz; req_unsigned = uns;
        req_addr = addr; req_wdata = wd;
        @(posedge clock);
        #1 req_valid = 1'b0;
        l = 0; nr = 0; nw = 0; waddr = '0; wdat = '0; rd = 'x; er = 'x; done = 0;
        for (int i = 0; i < 10 && !done; i++) begin
            @(negedge clock);
            l++;
            if (mem_read) nr++;
            if (mem_write) begin nw++; waddr = mem_addr; wdat = mem_wdata; end
            if (resp_valid) begin rd = resp_rdata; er = resp_error; done = 1; end
        end
        if (!done) l = 99;
    endtask

    task automatic test_reset;
        reset = 1'b0; req_valid = 1'b0; req_write = 1'b0; req_size = 2'b00;
        req_unsigned = 1'b0; req_addr = '0; req_wdata = '0;
        repeat (2) @(negedge clock);
        checks++; if (req_ready !== 1'b0) begin errors++; $display("FAIL rst_ready got %b want 0", req_ready); end
        checks++; if (resp_valid !== 1'b0) begin errors++; $display("FAIL rst_resp_valid got %b want 0", resp_valid); end
        checks++; if ({mem_read, mem_write} !== 2'b00) begin errors++; $display("FAIL rst_mem_en got %b want 00", {mem_read, mem_write}); end
        checks++; if (mem_addr !== 32'h0 || mem_wdata !== 32'h0) begin errors++; $display("FAIL rst_mem_bus got %h/%h want 0/0", mem_addr, mem_wdata); end
        checks++; if (resp_rdata !== 32'h0 || resp_error !== 2'b00) begin errors++; $display("FAIL rst_resp got %h/%b want 0/00", resp_rdata, resp_error); end
        reset = 1'b1;
        @(posedge clock); #1;
        checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL rst_release_ready got %b want 1", req_ready); end
    endtask

    task automatic test_loads;
        preload(9'd5, 32'h8091A2B3);
        do_req(1'b0, 2'b00, 1'b0, 32'h15, 32'h0, r, e, lat, nrd, nwr, wa, wdd);
        checks++; if (r !== 32'hFFFFFFA2) begin errors++; $display("FAIL lb_rdata got %h want FFFFFFA2", r); end
        checks++; if (lat !== 2 || e !== 2'b00) begin errors++; $display("FAIL lb_lat_err got %0d/%b want 2/00", lat, e); end
        checks++; if (nrd !== 1 || nwr !== 0) begin errors++; $display("FAIL lb_strobes got rd%0d wr%0d want rd1 wr0", nrd, nwr); end
        do_req(1'b0, 2'b00, 1'b1, 32'h15, 32'h0, r, e, lat, nrd, nwr, wa, wdd);
        checks++; if (r !== 32'h000000A2) begin errors++; $display("FAIL lbu_rdata got %h want 000000A2", r); end
        do_req(1'b0, 2'b01, 1'b0, 32'h16, 32'h0, r, e, lat, nrd, nwr, wa, wdd);
        checks++; if (r !== 32'hFFFF8091) begin errors++; $display("FAIL lh_rdata got %h want FFFF8091", r); end
        do_req(1'b0, 2'b01, 1'b1, 32'h16, 32'h0, r, e, lat, nrd, nwr, wa, wdd);
        checks++; if (r !== 32'h00008091) begin errors++; $display("FAIL lhu_rdata got %h want 00008091", r); end
        do_req(1'b0, 2'b00, 1'b0, 32'h14, 32'h0, r, e, lat, nrd, nwr, wa, wdd);
        checks++; if (r !== 32'hFFFFFFB3) begin errors++; $display("FAIL lb_lane0 got %h want FFFFFFB3", r); end
        do_req(1'b0, 2'b10, 1'b1, 32'h14, 32'h0, r, e, lat, nrd, nwr, wa, wdd);
        checks++; if (r !== 32'h8091A2B3 || lat !== 2) begin errors++; $display("FAIL lw_rdata_lat got %h/%0d want 8091A2B3/2", r, lat); end
    endtask

    task automatic test_byte_store;
        do_req(1'b1, 2'b00, 1'b0, 32'h17, 32'h000000CC, r, e, lat, nrd, nwr, wa, wdd);
        checks++; if (nrd !== 1 || nwr !== 1) begin errors++; $display("FAIL sb_strobes got rd%0d wr%0d want rd1 wr1", nrd, nwr); end
        checks++; if (wa !== 32'd5 || wdd !== 32'hCC91A2B3) begin errors++; $display("FAIL sb_mem_bus got %h/%h want 5/CC91A2B3", wa, wdd); end
        checks++; if (lat !== 3 || r !== 32'h0 || e !== 2'b00) begin errors++; $display("FAIL sb_resp got lat%0d %h %b want lat3 0 00", lat, r, e); end
        do_req(1'b0, 2'b10, 1'b0, 32'h14, 32'h0, r, e, lat, nrd, nwr, wa, wdd);
        checks++; if (r !== 32'hCC91A2B3) begin errors++; $display("FAIL sb_readback got %h want CC91A2B3", r); end
    endtask

    task automatic test_half_word_store;
        preload(9'd5, 32'h8091A2B3);
        do_req(1'b1, 2'b01, 1'b0, 32'h14, 32'h00001234, r, e, lat, nrd, nwr, wa, wdd);
        checks++; if (lat !== 3 || wdd !== 32'h80911234) begin errors++; $display("FAIL sh_wdata_lat got %h/%0d want 80911234/3", wdd, lat); end
        checks++; if (mem[5] !== 32'h80911234) begin errors++; $display("FAIL sh_mem got %h want 80911234", mem[5]); end
        do_req(1'b1, 2'b01, 1'b0, 32'h16, 32'hFFFF5678, r, e, lat, nrd, nwr, wa, wdd);
        checks++; if (mem[5] !== 32'h56781234) begin errors++; $display("FAIL sh_upper_mem got %h want 56781234", mem[5]); end
        do_req(1'b1, 2'b10, 1'b0, 32'h14, 32'hDEADBEEF, r, e, lat, nrd, nwr, wa, wdd);
        checks++; if (nrd !== 0 || nwr !== 1 || lat !== 2) begin errors++; $display("FAIL sw_shape got rd%0d wr%0d lat%0d want rd0 wr1 lat2", nrd, nwr, lat); end
        checks++; if (mem[5] !== 32'hDEADBEEF) begin errors++; $display("FAIL sw_mem got %h want DEADBEEF", mem[5]); end
    endtask

    task automatic test_errors;
        do_req(1'b1, 2'b10, 1'b0, 32'h22, 32'h12345678, r, e, lat, nrd, nwr, wa, wdd);
        checks++; if (e !== 2'b01 || lat !== 1 || nrd + nwr !== 0) begin errors++; $display("FAIL err_misaligned got %b lat%0d strobes%0d want 01 lat1 0", e, lat, nrd + nwr); end
        do_req(1'b0, 2'b10, 1'b0, 32'h800, 32'h0, r, e, lat, nrd, nwr, wa, wdd);
        checks++; if (e !== 2'b10 || lat !== 1 || nrd + nwr !== 0 || r !== 32'h0) begin errors++; $display("FAIL err_range got %b lat%0d strobes%0d %h want 10 lat1 0 0", e, lat, nrd + nwr, r); end
        do_req(1'b0, 2'b11, 1'b0, 32'h14, 32'h0, r, e, lat, nrd, nwr, wa, wdd);
        checks++; if (e !== 2'b11 || lat !== 1 || nrd + nwr !== 0 || r !== 32'h0) begin errors++; $display("FAIL err_size got %b lat%0d strobes%0d %h want 11 lat1 0 0", e, lat, nrd + nwr, r); end
        do_req(1'b1, 2'b11, 1'b0, 32'h801, 32'h0, r, e, lat, nrd, nwr, wa, wdd);
        checks++; if (e !== 2'b11) begin errors++; $display("FAIL err_prio_size got %b want 11", e); end
        do_req(1'b0, 2'b01, 1'b0, 32'h801, 32'h0, r, e, lat, nrd, nwr, wa, wdd);
        checks++; if (e !== 2'b01) begin errors++; $display("FAIL err_prio_align got %b want 01", e); end
        do_req(1'b0, 2'b00, 1'b0, 32'h7FF, 32'h0, r, e, lat, nrd, nwr, wa, wdd);
        checks++; if (e !== 2'b00 || lat !== 2) begin errors++; $display("FAIL last_word_ok got %b lat%0d want 00 lat2", e, lat); end
        checks++; if (mem[5] !== 32'hDEADBEEF) begin errors++; $display("FAIL err_mem_untouched got %h want DEADBEEF", mem[5]); end
    endtask

    task automatic test_reset_mid_write;
        int seen;
        preload(9'd5, 32'h11223344);
        @(negedge clock);
        req_valid = 1'b1; req_write = 1'b1; req_size = 2'b10; req_unsigned = 1'b0;
        req_addr = 32'h14; req_wdata = 32'h0;
        @(posedge clock);
        #1 req_valid = 1'b0;
        checks++; if (mem_write !== 1'b1) begin errors++; $display("FAIL rmw_in_wr got %b want 1", mem_write); end
        reset = 1'b0;
        #1;
        checks++; if (mem_write !== 1'b0 || req_ready !== 1'b0) begin errors++; $display("FAIL rmw_async got wr%b rdy%b want wr0 rdy0", mem_write, req_ready); end
        seen = 0;
        repeat (2) begin @(negedge clock); if (resp_valid) seen++; end
        reset = 1'b1;
        repeat (3) begin @(negedge clock); if (resp_valid) seen++; end
        checks++; if (seen !== 0) begin errors++; $display("FAIL rmw_no_resp got %0d want 0", seen); end
        checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL rmw_ready got %b want 1", req_ready); end
        checks++; if (mem[5] !== 32'h11223344) begin errors++; $display("FAIL rmw_mem got %h want 11223344", mem[5]); end
    endtask

    task automatic test_back_to_back;
        logic        t_wr [5];
        logic [1:0]  t_sz [5];
        logic [31:0] t_ad [5];
        logic [31:0] t_wd [5];
        logic [31:0] t_exp [5];
        int          t_gap [4];
        int idx, nresp, cyc, last_acc;
        logic rdy;
        t_wr = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
        t_sz = '{2'b10, 2'b00, 2'b10, 2'b00, 2'b10};
        t_ad = '{32'h14, 32'h18, 32'h18, 32'h1B, 32'h18};
        t_wd = '{32'h0, 32'h0000AB55, 32'h0, 32'h00000077, 32'h0};
        t_exp = '{32'h8091A2B3, 32'h0, 32'h00000055, 32'h0, 32'h77000055};
        t_gap = '{3, 4, 3, 4};
        preload(9'd5, 32'h8091A2B3);
        preload(9'd6, 32'h00000000);
        idx = 0; nresp = 0; cyc = 0; last_acc = 0;
        while ((idx < 5 || nresp < 5) && cyc < 100) begin
            @(negedge clock);
            cyc++;
            if (resp_valid) begin
                checks++;
                if (nresp >= 5 || resp_rdata !== t_exp[nresp] || resp_error !== 2'b00) begin
                    errors++; $display("FAIL b2b_resp%0d got %h/%b want %h/00", nresp, resp_rdata, resp_error, t_exp[nresp % 5]);
                end
                nresp++;
            end
            if (idx < 5) begin
                req_valid = 1'b1; req_write = t_wr[idx]; req_size = t_sz[idx];
                req_unsigned = 1'b0; req_addr = t_ad[idx]; req_wdata = t_wd[idx];
            end else begin
                req_valid = 1'b0;
            end
            rdy = req_ready;
            @(posedge clock);
            if (rdy && idx < 5) begin
                if (idx > 0) begin
                    checks++;
                    if (cyc - last_acc !== t_gap[idx - 1]) begin
                        errors++; $display("FAIL b2b_gap%0d got %0d want %0d", idx, cyc - last_acc, t_gap[idx - 1]);
                    end
                end
                last_acc = cyc;
                idx++;
            end
        end
        checks++; if (nresp !== 5) begin errors++; $display("FAIL b2b_count got %0d want 5", nresp); end
        checks++; if (mem[6] !== 32'h77000055) begin errors++; $display("FAIL b2b_mem got %h want 77000055", mem[6]); end
    endtask

    initial begin
        test_reset();
        test_loads();
        test_byte_store();
        test_half_word_store();
        test_errors();
        test_reset_mid_write();
        test_back_to_back();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
